// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: stall/flush sequencing, EX operand forwarding,
// and data-memory wait tracking. Define HAZARD_PERF_EN to add load-use/memory stall counters.
module hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] rs1_id_i,
  input  logic [4:0] rs2_id_i,
  input  logic [4:0] rs1_ex_i,
  input  logic [4:0] rs2_ex_i,
  input  logic [4:0] rd_ex_i,
  input  logic       MemRead_ex_i,
  input  logic       PCsrc_ex_i,
  input  logic [4:0] rd_mem_i,
  input  logic       RegWrite_mem_i,
  input  logic [4:0] rd_wb_i,
  input  logic       RegWrite_wb_i,
  input  logic       dmem_req_i,
  input  logic       dmem_ready_i,
  output logic       stall_if_o,
  output logic       stall_id_o,
  output logic       stall_ex_o,
  output logic       stall_mem_o,
  output logic       flush_id_o,
  output logic       flush_ex_o,
  output logic [1:0] forwardA_o,
  output logic [1:0] forwardB_o,
  output logic       mem_timeout_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] lu_stall_cnt_o,
  output logic [31:0] mem_stall_cnt_o
`endif
);

  typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_SAT    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             lu;
  logic             mem_stall;
  logic             lu_bubble;

  // MEM has priority over WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_mem, input logic wr_mem,
                                         input logic [4:0] rd_wb,  input logic wr_wb);
    if (wr_mem && (rd_mem != 5'd0) && (rd_mem == rs))
      return 2'b10;
    else if (wr_wb && (rd_wb != 5'd0) && (rd_wb == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign lu = MemRead_ex_i && (rd_ex_i != 5'd0) &&
              ((rd_ex_i == rs1_id_i) || (rd_ex_i == rs2_id_i));

  // In MEM_WAIT the request is already outstanding, so only ready matters.
  assign mem_stall = (state == MEM_WAIT) ? !dmem_ready_i : (dmem_req_i && !dmem_ready_i);

  assign lu_bubble = !rst_i && !mem_stall && !PCsrc_ex_i && lu;

  assign cnt_inc = (state == RUN)       ? CNT_ONE  :
                   (wait_cnt == CNT_SAT) ? wait_cnt : wait_cnt + CNT_ONE;

  always_comb begin
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    forwardA_o  = 2'b00;
    forwardB_o  = 2'b00;
    if (!rst_i) begin
      forwardA_o = fwd_sel(rs1_ex_i, rd_mem_i, RegWrite_mem_i, rd_wb_i, RegWrite_wb_i);
      forwardB_o = fwd_sel(rs2_ex_i, rd_mem_i, RegWrite_mem_i, rd_wb_i, RegWrite_wb_i);
      if (mem_stall) begin
        stall_if_o  = 1'b1;
        stall_id_o  = 1'b1;
        stall_ex_o  = 1'b1;
        stall_mem_o = 1'b1;
      end else if (PCsrc_ex_i) begin
        flush_id_o = 1'b1;
        flush_ex_o = 1'b1;
      end else if (lu) begin
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
        flush_ex_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= RUN;
      wait_cnt      <= '0;
      mem_timeout_o <= 1'b0;
    end else if (mem_stall) begin
      state    <= MEM_WAIT;
      wait_cnt <= cnt_inc;
      if (cnt_inc >= MAX_WAIT_C)
        mem_timeout_o <= 1'b1;
    end else begin
      state    <= RUN;
      wait_cnt <= '0;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lu_stall_cnt_o  <= '0;
      mem_stall_cnt_o <= '0;
    end else begin
      if (lu_bubble)
        lu_stall_cnt_o <= lu_stall_cnt_o + 32'd1;
      if (mem_stall)
        mem_stall_cnt_o <= mem_stall_cnt_o + 32'd1;
    end
  end
`else
  logic unused_lu_bubble;
  assign unused_lu_bubble = lu_bubble;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed literal checks plus randomized stimulus
// compared every cycle against a behavioural model.
module tb_hazard_ctrl;
  localparam int MAX_WAIT = 16;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [4:0] rs1_id_i, rs2_id_i, rs1_ex_i, rs2_ex_i, rd_ex_i, rd_mem_i, rd_wb_i;
  logic       MemRead_ex_i, PCsrc_ex_i, RegWrite_mem_i, RegWrite_wb_i;
  logic       dmem_req_i, dmem_ready_i;
  logic       stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
  logic       flush_id_o, flush_ex_o, mem_timeout_o;
  logic [1:0] forwardA_o, forwardB_o;
`ifdef HAZARD_PERF_EN
  logic [31:0] lu_stall_cnt_o, mem_stall_cnt_o;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .rs1_id_i(rs1_id_i), .rs2_id_i(rs2_id_i),
    .rs1_ex_i(rs1_ex_i), .rs2_ex_i(rs2_ex_i),
    .rd_ex_i(rd_ex_i), .MemRead_ex_i(MemRead_ex_i), .PCsrc_ex_i(PCsrc_ex_i),
    .rd_mem_i(rd_mem_i), .RegWrite_mem_i(RegWrite_mem_i),
    .rd_wb_i(rd_wb_i), .RegWrite_wb_i(RegWrite_wb_i),
    .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o),
    .stall_ex_o(stall_ex_o), .stall_mem_o(stall_mem_o),
    .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o),
    .forwardA_o(forwardA_o), .forwardB_o(forwardB_o),
    .mem_timeout_o(mem_timeout_o)
`ifdef HAZARD_PERF_EN
    ,
    .lu_stall_cnt_o(lu_stall_cnt_o), .mem_stall_cnt_o(mem_stall_cnt_o)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit model_on = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Behavioural model state: are we inside a wait, how long it has lasted, sticky flag, counters.
  bit          m_in_wait  = 1'b0;
  int          m_wait_len = 0;
  bit          m_timeout  = 1'b0;
  int unsigned m_lu_cnt   = 0;
  int unsigned m_mem_cnt  = 0;

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (RegWrite_mem_i && rd_mem_i != 0 && rd_mem_i == rs) return 2'b10;
    if (RegWrite_wb_i && rd_wb_i != 0 && rd_wb_i == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      logic [1:0] e_fa, e_fb;
      bit e_sif, e_sid, e_sex, e_smem, e_fid, e_fex, waiting, load_use;
      e_fa = 2'b00; e_fb = 2'b00;
      e_sif = 0; e_sid = 0; e_sex = 0; e_smem = 0; e_fid = 0; e_fex = 0;
      waiting  = m_in_wait ? !dmem_ready_i : (dmem_req_i && !dmem_ready_i);
      load_use = MemRead_ex_i && rd_ex_i != 0 && (rd_ex_i == rs1_id_i || rd_ex_i == rs2_id_i);
      if (!rst_i) begin
        e_fa = m_fwd(rs1_ex_i);
        e_fb = m_fwd(rs2_ex_i);
        if (waiting) begin
          e_sif = 1; e_sid = 1; e_sex = 1; e_smem = 1;
        end else if (PCsrc_ex_i) begin
          e_fid = 1; e_fex = 1;
        end else if (load_use) begin
          e_sif = 1; e_sid = 1; e_fex = 1;
        end
      end
      chk1("m_stall_if", stall_if_o, e_sif);
      chk1("m_stall_id", stall_id_o, e_sid);
      chk1("m_stall_ex", stall_ex_o, e_sex);
      chk1("m_stall_mem", stall_mem_o, e_smem);
      chk1("m_flush_id", flush_id_o, e_fid);
      chk1("m_flush_ex", flush_ex_o, e_fex);
      chk2("m_forwardA", forwardA_o, e_fa);
      chk2("m_forwardB", forwardB_o, e_fb);
      chk1("m_timeout", mem_timeout_o, m_timeout);
`ifdef HAZARD_PERF_EN
      chk32("m_lu_cnt", lu_stall_cnt_o, m_lu_cnt);
      chk32("m_mem_cnt", mem_stall_cnt_o, m_mem_cnt);
`endif
      // Advance the model to the state seen after the coming rising edge.
      if (rst_i) begin
        m_in_wait = 0; m_wait_len = 0; m_timeout = 0; m_lu_cnt = 0; m_mem_cnt = 0;
      end else if (waiting) begin
        m_in_wait = 1;
        m_wait_len++;
        if (m_wait_len >= MAX_WAIT) m_timeout = 1;
        m_mem_cnt++;
      end else begin
        m_in_wait = 0;
        m_wait_len = 0;
        if (!PCsrc_ex_i && load_use) m_lu_cnt++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_id_i = 0; rs2_id_i = 0; rs1_ex_i = 0; rs2_ex_i = 0; rd_ex_i = 0;
    rd_mem_i = 0; rd_wb_i = 0; MemRead_ex_i = 0; PCsrc_ex_i = 0;
    RegWrite_mem_i = 0; RegWrite_wb_i = 0; dmem_req_i = 0; dmem_ready_i = 0;
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    @(posedge clk); #1;
    model_on = 1'b1;

    // Reset forces outputs low even with live hazards on the inputs.
    RegWrite_mem_i = 1; rd_mem_i = 5; rs1_ex_i = 5; dmem_req_i = 1;
    #2;
    chk2("rst_forwardA", forwardA_o, 2'b00);
    chk1("rst_stall_mem", stall_mem_o, 1'b0);

    cyc(); rst_i = 0; idle();
    RegWrite_mem_i = 1; rd_mem_i = 5; RegWrite_wb_i = 1; rd_wb_i = 5; rs1_ex_i = 5;
    #2;
    chk2("fwd_mem_prio", forwardA_o, 2'b10);
    chk1("timeout_after_rst", mem_timeout_o, 1'b0);

    cyc(); rd_mem_i = 0;
    #2; chk2("fwd_wb", forwardA_o, 2'b01);

    cyc(); rs1_ex_i = 0; rd_wb_i = 0; rd_mem_i = 7; rs2_ex_i = 7;
    #2;
    chk2("fwd_none", forwardA_o, 2'b00);
    chk2("fwdB_mem", forwardB_o, 2'b10);

    cyc(); idle(); MemRead_ex_i = 1; rd_ex_i = 3; rs2_id_i = 3;
    #2;
    chk1("lu_stall_if", stall_if_o, 1'b1);
    chk1("lu_stall_id", stall_id_o, 1'b1);
    chk1("lu_flush_ex", flush_ex_o, 1'b1);
    chk1("lu_stall_ex", stall_ex_o, 1'b0);

    cyc(); idle();
    #2; chk1("lu_one_cycle", stall_if_o, 1'b0);

    cyc(); MemRead_ex_i = 1; rd_ex_i = 0;
    #2;
    chk1("lu_x0_stall", stall_if_o, 1'b0);
    chk1("lu_x0_flush", flush_ex_o, 1'b0);

    cyc(); MemRead_ex_i = 1; rd_ex_i = 3; rs2_id_i = 3; PCsrc_ex_i = 1;
    #2;
    chk1("redir_flush_id", flush_id_o, 1'b1);
    chk1("redir_flush_ex", flush_ex_o, 1'b1);
    chk1("redir_stall_if", stall_if_o, 1'b0);

    // Four-cycle memory wait; a redirect during the wait must not flush.
    for (int j = 1; j <= 4; j++) begin
      cyc(); idle(); dmem_req_i = 1; dmem_ready_i = 0; PCsrc_ex_i = (j == 2);
      #2;
      chk1("wait_stall_if", stall_if_o, 1'b1);
      chk1("wait_stall_mem", stall_mem_o, 1'b1);
      chk1("wait_flush_id", flush_id_o, 1'b0);
    end
    cyc(); idle(); dmem_req_i = 1; dmem_ready_i = 1;
    #2;
    chk1("ready_stall_if", stall_if_o, 1'b0);
    chk1("ready_stall_mem", stall_mem_o, 1'b0);
    cyc(); idle();
    #2; chk1("short_wait_no_timeout", mem_timeout_o, 1'b0);

    // Twenty-cycle wait: the flag becomes visible in the 17th wait cycle.
    for (int j = 1; j <= 20; j++) begin
      cyc(); idle(); dmem_req_i = 1;
      #2;
      if (j == 16) chk1("timeout_wait16", mem_timeout_o, 1'b0);
      if (j == 17) chk1("timeout_wait17", mem_timeout_o, 1'b1);
    end
    cyc(); dmem_ready_i = 1;
    #2;
    chk1("timeout_sticky_ready", mem_timeout_o, 1'b1);
    chk1("timeout_ready_stall", stall_if_o, 1'b0);
    cyc(); idle();
    #2; chk1("timeout_sticky_idle", mem_timeout_o, 1'b1);
    cyc(); rst_i = 1;
    cyc(); rst_i = 0;
    #2;
    chk1("timeout_cleared", mem_timeout_o, 1'b0);
    chk1("post_rst_stall", stall_if_o, 1'b0);

    // Reset aborts a wait in progress.
    for (int j = 1; j <= 3; j++) begin
      cyc(); idle(); dmem_req_i = 1;
    end
    cyc(); idle(); rst_i = 1;
    #2;
    chk1("midwait_rst_stall", stall_mem_o, 1'b0);
`ifdef HAZARD_PERF_EN
    chk32("midwait_mem_cnt", mem_stall_cnt_o, 32'd3);
`endif
    cyc(); rst_i = 0;
    #2;
    chk1("after_abort_stall", stall_mem_o, 1'b0);
`ifdef HAZARD_PERF_EN
    chk32("after_abort_lu_cnt", lu_stall_cnt_o, 32'd0);
    chk32("after_abort_mem_cnt", mem_stall_cnt_o, 32'd0);
`endif

    // Randomized phase alternating between responsive and sluggish memory.
    for (int i = 0; i < 4000; i++) begin
      bit slow;
      cyc();
      slow = ((i / 250) % 2) == 1;
      rst_i          = slow ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 99) == 0);
      rs1_id_i       = 5'($urandom_range(0, 3));
      rs2_id_i       = 5'($urandom_range(0, 3));
      rs1_ex_i       = 5'($urandom_range(0, 3));
      rs2_ex_i       = 5'($urandom_range(0, 3));
      rd_ex_i        = 5'($urandom_range(0, 3));
      rd_mem_i       = 5'($urandom_range(0, 3));
      rd_wb_i        = 5'($urandom_range(0, 3));
      MemRead_ex_i   = 1'($urandom_range(0, 1));
      PCsrc_ex_i     = ($urandom_range(0, 3) == 0);
      RegWrite_mem_i = 1'($urandom_range(0, 1));
      RegWrite_wb_i  = 1'($urandom_range(0, 1));
      dmem_req_i     = ($urandom_range(0, 2) == 0);
      dmem_ready_i   = slow ? ($urandom_range(0, 29) == 0) : 1'($urandom_range(0, 1));
    end

    cyc(); idle(); rst_i = 0;
    @(posedge clk); #1;
    model_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core; sequences the register-read/decode stage and its ID/EX pipeline register.
- Generates stall (hold) and flush (bubble) controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus forwarding selects for EX operands A/B.
- Tracks multi-cycle data-memory waits in a small FSM and raises a sticky timeout flag.

Parameters:
- MAX_WAIT, 16, maximum consecutive data-memory wait cycles before mem_timeout_o sets (1..255)
- CNT_W, 8, width of the internal wait counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- rs1_id_i  in  5  rs1 of the instruction in ID
- rs2_id_i  in  5  rs2 of the instruction in ID
- rs1_ex_i  in  5  rs1 of the instruction in EX
- rs2_ex_i  in  5  rs2 of the instruction in EX
- rd_ex_i  in  5  destination register in EX
- MemRead_ex_i  in  1  EX instruction is a load
- PCsrc_ex_i  in  1  EX branch taken / jump / ret redirect
- rd_mem_i  in  5  destination register in MEM
- RegWrite_mem_i  in  1  MEM instruction writes the register file
- rd_wb_i  in  5  destination register in WB
- RegWrite_wb_i  in  1  WB instruction writes the register file
- dmem_req_i  in  1  MEM stage issuing a data-memory access
- dmem_ready_i  in  1  data memory completes the access this cycle
- stall_if_o  out  1  hold PC
- stall_id_o  out  1  hold IF/ID
- stall_ex_o  out  1  hold ID/EX
- stall_mem_o  out  1  hold EX/MEM and MEM/WB
- flush_id_o  out  1  clear IF/ID to NOP
- flush_ex_o  out  1  clear ID/EX to bubble (all control bits 0)
- forwardA_o  out  2  EX operand A source: 00 reg, 01 WB, 10 MEM
- forwardB_o  out  2  EX operand B source, same encoding
- mem_timeout_o  out  1  sticky; set when a wait reaches MAX_WAIT cycles

Behaviour:
- Clocking and reset:
  - All state updates on the rising clk_i.
  - rst_i is synchronous, active-high. On reset the FSM enters RUN, wait counter=0, mem_timeout_o=0.
  - While rst_i is high, all stall/flush outputs are forced 0 and forwardA_o/forwardB_o are forced 00.
- Forwarding (combinational, every cycle):
  - forwardA_o=10 if RegWrite_mem_i, rd_mem_i!=0 and rd_mem_i==rs1_ex_i.
  - Else 01 if RegWrite_wb_i, rd_wb_i!=0 and rd_wb_i==rs1_ex_i.
  - Else 00. MEM has priority over WB. forwardB_o uses rs2_ex_i identically.
  - Forwarding stays valid during stalls.
- Load-use detection (combinational): lu = MemRead_ex_i and rd_ex_i!=0 and (rd_ex_i==rs1_id_i or rd_ex_i==rs2_id_i).
- FSM states RUN, MEM_WAIT:
  - RUN, with dmem_req_i=1 and dmem_ready_i=0:
    - Assert all four stall outputs the same cycle; no flush.
    - Go to MEM_WAIT; counter <= 1.
  - MEM_WAIT:
    - All stall outputs stay 1; flushes 0 (pipeline frozen, including any pending redirect or load-use).
    - Counter increments, saturating at 2^CNT_W-1.
    - When the counter reaches MAX_WAIT, mem_timeout_o <= 1 (sticky until reset); the wait continues.
    - dmem_ready_i=1: stalls deassert that same cycle and the FSM returns to RUN with counter <= 0.
  - RUN, no memory wait; priority is redirect > load-use:
    - PCsrc_ex_i=1: flush_id_o=1, flush_ex_o=1, no stalls. A coincident load-use is discarded, since the younger instruction is flushed.
    - Else lu=1: stall_if_o=1, stall_id_o=1, flush_ex_o=1 for exactly one cycle. On the next cycle the load has moved to MEM and lu clears naturally; it is not re-evaluated against a stale rd.
    - Else all outputs 0.
- Outputs other than mem_timeout_o are combinational from state and inputs; zero-cycle latency.
- rst_i asserted mid-MEM_WAIT aborts the wait; the next cycle is RUN.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds 32-bit output ports lu_stall_cnt_o and mem_stall_cnt_o.
  - lu_stall_cnt_o increments on each load-use bubble cycle.
  - mem_stall_cnt_o increments on each memory-stall cycle.
  - Both wrap at 2^32 and reset to 0.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Test Plan:
- Forwarding: RegWrite_mem_i=1, rd_mem_i=5, RegWrite_wb_i=1, rd_wb_i=5, rs1_ex_i=5 -> forwardA_o=10. Then rd_mem_i=0 -> forwardA_o=01. Then rs1_ex_i=0 with rd_wb_i=0 -> 00.
- Load-use: MemRead_ex_i=1, rd_ex_i=3, rs2_id_i=3 -> one cycle of stall_if_o=stall_id_o=flush_ex_o=1. Repeat with rd_ex_i=0 -> no stall.
- Redirect vs load-use: PCsrc_ex_i=1 with a load-use condition -> flush_id_o=flush_ex_o=1, stall_if_o=0.
- Memory wait: dmem_req_i=1, dmem_ready_i=0 for 4 cycles, then ready -> all stalls 1 for 4 cycles, 0 on the ready cycle, FSM in RUN. With MAX_WAIT=16, mem_timeout_o stays 0.
- Timeout: hold ready low 20 cycles with MAX_WAIT=16 -> mem_timeout_o rises after the 16th wait cycle and remains 1 after ready. Then pulse rst_i -> mem_timeout_o=0, outputs 0.
- Reset mid-wait with HAZARD_PERF_EN: 3 wait cycles, rst_i=1 -> next cycle stalls 0 and both counters 0.
